// File: rtl/arb_pkg.sv
// arb_pkg: shared FSM state encoding and parameter defaults for arb_requester.
package arb_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_RELEASE} state_e;
    localparam int LEN_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;
endpackage

// File: rtl/arb_requester.sv
// arb_requester: client agent that requests a 3-way arbiter and issues one beat per granted cycle.
// Ports: clk/res_n (async active-low), cmd_valid/cmd_len/cmd_ready command handshake,
// abort withdraws an ungranted request, req/grant arbiter handshake,
// beat_valid/beat_idx/done beat stream, busy (not IDLE), wait_timeout grant-wait pulse.
module arb_requester
    import arb_pkg::*;
#(
    parameter int LEN_W   = LEN_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             req,
    input  logic             grant,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             done,
    output logic             busy,
    output logic             wait_timeout
);
    localparam logic [7:0] TO = 8'(TIMEOUT);
    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d, idx_q, idx_d;
    logic [7:0]       wait_q, wait_d;
    logic             req_q, last;
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        beat_valid = (state_q == ST_REQ || state_q == ST_XFER) && grant;
        last       = beat_valid && rem_q == '0;
        case (state_q)
            ST_IDLE: if (cmd_valid) begin
                state_d = ST_REQ;
                rem_d   = cmd_len;
                idx_d   = '0;
                wait_d  = '0;
            end
            ST_REQ, ST_XFER:
                if (beat_valid) begin
                    rem_d   = rem_q - LEN_W'(1);
                    idx_d   = idx_q + LEN_W'(1);
                    state_d = last ? ST_RELEASE : ST_XFER;
                end else if (state_q == ST_REQ && abort) state_d = ST_RELEASE;
                else if (state_q == ST_REQ && wait_q != TO) wait_d = wait_q + 8'd1;
            ST_RELEASE: if (!grant) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            wait_q  <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            wait_q  <= wait_d;
            req_q   <= state_d == ST_REQ || state_d == ST_XFER;
        end
    end
    // Saturated counter stops matching TIMEOUT-1, so the pulse fires only once per wait.
    assign wait_timeout = state_q == ST_REQ && !grant && wait_q == TO - 8'd1;
    assign cmd_ready    = state_q == ST_IDLE;
    assign busy         = state_q != ST_IDLE;
    assign done         = last;
    assign beat_idx     = idx_q;
    assign req          = req_q;
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: directed self-checking bench for arb_requester.
module tb_arb_requester;
    logic       clk = 0, res_n = 0, cmd_valid = 0, abort = 0, grant = 0;
    logic [3:0] cmd_len = 0;
    logic       cmd_ready, req, beat_valid, done, busy, wait_timeout;
    logic [3:0] beat_idx;
    int n_cmp = 0, n_err = 0, beats = 0, pulses = 0, dones = 0;

    arb_requester dut (
        .clk(clk), .res_n(res_n), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .abort(abort), .req(req), .grant(grant),
        .beat_valid(beat_valid), .beat_idx(beat_idx), .done(done),
        .busy(busy), .wait_timeout(wait_timeout)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        #2;
        chk("rst_req", int'(req), 0);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_beat", int'(beat_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_to", int'(wait_timeout), 0);
        @(negedge clk);
        res_n = 1;
        cyc();

        // single beat, grant one cycle after req
        cmd_valid = 1; cmd_len = 0; #1;
        chk("s_ready", int'(cmd_ready), 1);
        cyc(); cmd_valid = 0; #1;
        chk("s_req_t1", int'(req), 1);
        chk("s_beat_t1", int'(beat_valid), 0);
        cyc(); grant = 1; #1;
        chk("s_beat_t2", int'(beat_valid), 1);
        chk("s_done_t2", int'(done), 1);
        chk("s_idx_t2", int'(beat_idx), 0);
        cyc(); #1;
        chk("s_req_t3", int'(req), 0);
        chk("s_beat_t3", int'(beat_valid), 0);
        chk("s_done_t3", int'(done), 0);
        chk("s_busy_t3", int'(busy), 1);
        cyc(); grant = 0; #1;
        chk("s_busy_t4", int'(busy), 1);
        cyc(); #1;
        chk("s_ready_t5", int'(cmd_ready), 1);
        chk("s_busy_t5", int'(busy), 0);

        // burst of 4, continuous grant
        cmd_valid = 1; cmd_len = 3;
        cyc(); cmd_valid = 0; #1;
        chk("b_req", int'(req), 1);
        cyc(); grant = 1; #1;
        beats = 0; dones = 0;
        for (int i = 0; i < 4; i++) begin
            chk("b_valid", int'(beat_valid), 1);
            chk("b_idx", int'(beat_idx), i);
            chk("b_done", int'(done), i == 3 ? 1 : 0);
            beats += int'(beat_valid); dones += int'(done);
            cyc(); #1;
        end
        chk("b_rel_beat", int'(beat_valid), 0);
        chk("b_rel_req", int'(req), 0);
        chk("b_beats", beats, 4);
        chk("b_dones", dones, 1);
        cyc(); grant = 0; #1;
        cyc(); #1;
        chk("b_idle", int'(busy), 0);

        // grant delayed 20 cycles: one timeout pulse at REQ cycle 15
        cmd_valid = 1; cmd_len = 1;
        cyc(); cmd_valid = 0; #1;
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            chk("t_to", int'(wait_timeout), k == 15 ? 1 : 0);
            chk("t_req", int'(req), 1);
            pulses += int'(wait_timeout);
            cyc(); #1;
        end
        chk("t_pulses", pulses, 1);
        grant = 1; #1;
        chk("t_beat0", int'(beat_valid), 1);
        chk("t_idx0", int'(beat_idx), 0);
        chk("t_done0", int'(done), 0);
        cyc(); #1;
        chk("t_idx1", int'(beat_idx), 1);
        chk("t_done1", int'(done), 1);
        cyc(); grant = 0; #1;
        chk("t_req_rel", int'(req), 0);
        cyc(); #1;
        chk("t_idle", int'(cmd_ready), 1);

        // abort at REQ cycle 5
        cmd_valid = 1; cmd_len = 2;
        cyc(); cmd_valid = 0; #1;
        beats = 0; dones = 0;
        for (int k = 1; k <= 5; k++) begin
            abort = (k == 5); #1;
            beats += int'(beat_valid); dones += int'(done);
            cyc();
        end
        abort = 0; #1;
        chk("a_req", int'(req), 0);
        chk("a_busy", int'(busy), 1);
        chk("a_beats", beats, 0);
        chk("a_dones", dones, 0);
        cyc(); #1;
        chk("a_idle", int'(busy), 0);
        chk("a_ready", int'(cmd_ready), 1);

        // grant gap of 2 cycles after beat 2
        cmd_valid = 1; cmd_len = 5;
        cyc(); cmd_valid = 0;
        cyc(); grant = 1; #1;
        beats = 0;
        for (int i = 0; i < 3; i++) begin
            chk("g_idx_a", int'(beat_idx), i);
            beats += int'(beat_valid);
            cyc(); #1;
        end
        grant = 0; #1;
        for (int i = 0; i < 2; i++) begin
            chk("g_gap_beat", int'(beat_valid), 0);
            chk("g_gap_req", int'(req), 1);
            chk("g_gap_idx", int'(beat_idx), 3);
            cyc(); #1;
        end
        grant = 1; #1;
        for (int i = 3; i < 6; i++) begin
            chk("g_idx_b", int'(beat_idx), i);
            chk("g_done", int'(done), i == 5 ? 1 : 0);
            beats += int'(beat_valid);
            cyc(); #1;
        end
        chk("g_beats", beats, 6);
        grant = 0;
        cyc(); #1;
        chk("g_idle", int'(busy), 0);

        // reset during beat 1
        cmd_valid = 1; cmd_len = 3;
        cyc(); cmd_valid = 0;
        cyc(); grant = 1; #1;
        chk("r_beat0", int'(beat_valid), 1);
        cyc(); #1;
        chk("r_idx1", int'(beat_idx), 1);
        res_n = 0; #1;
        chk("r_async_req", int'(req), 0);
        chk("r_async_beat", int'(beat_valid), 0);
        chk("r_async_done", int'(done), 0);
        grant = 0;
        cyc(); res_n = 1;
        cyc(); #1;
        chk("r_ready", int'(cmd_ready), 1);
        chk("r_busy", int'(busy), 0);
        chk("r_done", int'(done), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
